// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // RV64 load/store size encodings
  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_ILL = 3'b111;

  // byte lanes in one doubleword
  localparam int LANES = 8;

  // Access size in bytes; the illegal code maps to 8 but is always flagged separately.
  function automatic logic [3:0] size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_bytes = 4'd1;
      2'b01:   size_bytes = 4'd2;
      2'b10:   size_bytes = 4'd4;
      default: size_bytes = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering between a doubleword row and a sized access.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]       funct3,
  input  logic [2:0]       addr_lo,
  input  logic [63:0]      raw,
  input  logic [63:0]      wdata,
  output logic [LANES-1:0] be,
  output logic [63:0]      wdata_sh,
  output logic [63:0]      rdata
);

  logic [LANES-1:0] base_mask;
  logic [63:0]      ld_sh;

  // Byte-enable mask for the access, moved to its position in the row
  always_comb begin
    base_mask = '0;
    case (funct3)
      F3_B, F3_BU: base_mask = 8'h01;
      F3_H, F3_HU: base_mask = 8'h03;
      F3_W, F3_WU: base_mask = 8'h0F;
      F3_D:        base_mask = 8'hFF;
      default:     base_mask = 8'h00;
    endcase
    be       = base_mask << addr_lo;
    wdata_sh = wdata << {addr_lo, 3'b000};
  end

  // Pull the addressed element down to bit 0 and extend it
  always_comb begin
    ld_sh = raw >> {addr_lo, 3'b000};
    case (funct3)
      F3_B:    rdata = {{56{ld_sh[7]}}, ld_sh[7:0]};
      F3_H:    rdata = {{48{ld_sh[15]}}, ld_sh[15:0]};
      F3_W:    rdata = {{32{ld_sh[31]}}, ld_sh[31:0]};
      F3_D:    rdata = ld_sh;
      F3_BU:   rdata = {56'd0, ld_sh[7:0]};
      F3_HU:   rdata = {48'd0, ld_sh[15:0]};
      F3_WU:   rdata = {32'd0, ld_sh[31:0]};
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Stall-capable data-memory responder: one request at a time, fixed wait, held response.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic [63:0] element1,
  output logic [63:0] element2,
  output logic [63:0] element3
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dmem_responder: WAIT_CYCLES must be in 0..15");
  end
  if (DEPTH_BYTES < 24 || (DEPTH_BYTES % 8) != 0 || (1 << IDX_W) != DEPTH_BYTES) begin : g_bad_depth
    $error("dmem_responder: DEPTH_BYTES must be a power of 2, multiple of 8, >= 24");
  end

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        lat_write;
  logic [63:0] lat_addr, lat_wdata;
  logic [2:0]  lat_f3;
  logic [7:0]  mem [DEPTH_BYTES];

  logic        accept, enter_resp;
  logic        cur_write, cur_err;
  logic [63:0] cur_addr, cur_wdata;
  logic [2:0]  cur_f3;
  logic [3:0]  size;
  logic        misaligned, out_of_range;
  logic [IDX_W-4:0] dw_idx;
  logic [63:0] raw_dw, wdata_sh, ld_data;
  logic [LANES-1:0] be;

  assign accept     = req_valid && req_ready;
  assign enter_resp = (state_q != RESP) && (state_d == RESP);

  // The access being resolved: live inputs when a zero-wait request enters RESP straight
  // from IDLE, otherwise the latched copy.
  always_comb begin
    if (state_q == IDLE) begin
      cur_write = req_write;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_f3    = req_funct3;
    end else begin
      cur_write = lat_write;
      cur_addr  = lat_addr;
      cur_wdata = lat_wdata;
      cur_f3    = lat_f3;
    end
  end

  // Error check: alignment, full-width range (65-bit sum so nothing wraps), illegal size
  always_comb begin
    size         = size_bytes(cur_f3);
    misaligned   = (cur_addr[3:0] & (size - 4'd1)) != 4'd0;
    out_of_range = ({1'b0, cur_addr} + {61'd0, size}) > 65'(DEPTH_BYTES);
    cur_err      = misaligned || out_of_range || (cur_f3 == F3_ILL);
  end

  // Doubleword row containing the access; aligned accesses never straddle rows
  always_comb begin
    dw_idx = cur_addr[IDX_W-1:3];
    raw_dw = '0;
    for (int b = 0; b < LANES; b++) raw_dw[b*8 +: 8] = mem[{dw_idx, 3'(b)}];
  end

  dmem_lane_align u_align (
    .funct3   (cur_f3),
    .addr_lo  (cur_addr[2:0]),
    .raw      (raw_dw),
    .wdata    (cur_wdata),
    .be       (be),
    .wdata_sh (wdata_sh),
    .rdata    (ld_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake outputs
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
      end
      WAIT: if (cnt_q <= 4'd1) state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Wait counter: loaded on accept, counts down while waiting
  always_ff @(posedge clk) begin
    if (reset)                cnt_q <= '0;
    else if (accept)          cnt_q <= 4'(WAIT_CYCLES);
    else if (state_q == WAIT) cnt_q <= cnt_q - 4'd1;
  end

  // Request latch
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_f3    <= '0;
    end else if (accept) begin
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_f3    <= req_funct3;
    end
  end

  // Byte storage: cleared by reset, store commits on the edge entering RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_BYTES; i++) mem[i] <= '0;
    end else if (enter_resp && cur_write && !cur_err) begin
      for (int b = 0; b < LANES; b++)
        if (be[b]) mem[{dw_idx, 3'(b)}] <= wdata_sh[b*8 +: 8];
    end
  end

  // Response registers, sampled together with the store commit and held through RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      rsp_err   <= cur_err;
      rsp_rdata <= (cur_write || cur_err) ? 64'd0 : ld_data;
    end
  end

  // Live views of the first three doublewords
  always_comb begin
    for (int b = 0; b < LANES; b++) begin
      element1[b*8 +: 8] = mem[b];
      element2[b*8 +: 8] = mem[8 + b];
      element3[b*8 +: 8] = mem[16 + b];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: WAIT_CYCLES=2 instance plus a zero-wait instance.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1, rst0 = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_funct3 = '0;

  logic        req_ready, rsp_valid, rsp_err;
  logic [63:0] rsp_rdata, element1, element2, element3;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [63:0] rsp_rdata0, element1_0, element2_0, element3_0;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_funct3(req_funct3), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .element1(element1), .element2(element2), .element3(element3)
  );

  dmem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst0), .req_valid(req_valid), .req_ready(req_ready0),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_funct3(req_funct3), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
    .element1(element1_0), .element2(element2_0), .element3(element3_0)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full transaction; called #1 after a rising edge with the selected DUT idle.
  task automatic txn(input string tag, input bit sel, input logic wr, input logic [63:0] a,
                     input logic [63:0] wd, input logic [2:0] f3,
                     input logic [63:0] exp_rd, input logic exp_err, input int exp_lat);
    int lat;
    chk({tag, ".req_ready"}, sel ? req_ready0 : req_ready, 1);
    req_write = wr; req_addr = a; req_wdata = wd; req_funct3 = f3; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!(sel ? rsp_valid0 : rsp_valid) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".rdata"}, sel ? rsp_rdata0 : rsp_rdata, exp_rd);
    chk({tag, ".err"}, 64'(sel ? rsp_err0 : rsp_err), 64'(exp_err));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n;
    // reset
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst.req_ready", 64'(req_ready), 1);
    chk("rst.rsp_valid", 64'(rsp_valid), 0);
    chk("rst.rdata", rsp_rdata, 0);
    chk("rst.err", 64'(rsp_err), 0);
    chk("rst.e1", element1, 0);
    chk("rst.e2", element2, 0);
    chk("rst.e3", element3, 0);

    // 1: doubleword store
    txn("sd0", 0, 1, 0, 64'h1122334455667788, F3_D, 0, 0, 3);
    chk("sd0.e1", element1, 64'h1122334455667788);

    // 2: byte/half loads, sign vs zero extension
    txn("lb7", 0, 0, 7, 0, F3_B, 64'h11, 0, 3);
    txn("lh6", 0, 0, 6, 0, F3_H, 64'h1122, 0, 3);
    txn("sb8", 0, 1, 8, 64'h80, F3_B, 0, 0, 3);
    chk("sb8.e2", element2, 64'h80);
    txn("lb8", 0, 0, 8, 0, F3_B, 64'hFFFFFFFFFFFFFF80, 0, 3);
    txn("lbu8", 0, 0, 8, 0, F3_BU, 64'h80, 0, 3);

    // 3: word store in upper half of a row
    txn("sw20", 0, 1, 20, 64'hDEADBEEF, F3_W, 0, 0, 3);
    chk("sw20.e3", element3, 64'hDEADBEEF00000000);
    txn("lw20", 0, 0, 20, 0, F3_W, 64'hFFFFFFFFDEADBEEF, 0, 3);
    txn("lwu20", 0, 0, 20, 0, F3_WU, 64'h00000000DEADBEEF, 0, 3);
    txn("lhu22", 0, 0, 22, 0, F3_HU, 64'hDEAD, 0, 3);

    // upper range boundary
    txn("sd56", 0, 1, 56, 64'hCAFEF00D12345678, F3_D, 0, 0, 3);
    txn("ld56", 0, 0, 56, 0, F3_D, 64'hCAFEF00D12345678, 0, 3);
    txn("lb63", 0, 0, 63, 0, F3_B, 64'hFFFFFFFFFFFFFFCA, 0, 3);

    // 4: error cases leave storage alone
    txn("ld4", 0, 0, 4, 0, F3_D, 0, 1, 3);
    txn("sh1", 0, 1, 1, 64'hFFFF, F3_H, 0, 1, 3);
    txn("sdoor", 0, 1, DEPTH, 64'hFFFFFFFFFFFFFFFF, F3_D, 0, 1, 3);
    txn("lwoor", 0, 0, 62, 0, F3_W, 0, 1, 3);
    txn("ldhi", 0, 0, 64'h8000000000000000, 0, F3_D, 0, 1, 3);
    txn("f3ld", 0, 0, 0, 0, F3_ILL, 0, 1, 3);
    txn("f3st", 0, 1, 8, 64'hFFFFFFFFFFFFFFFF, F3_ILL, 0, 1, 3);
    chk("err.e1", element1, 64'h1122334455667788);
    chk("err.e2", element2, 64'h80);
    chk("err.e3", element3, 64'hDEADBEEF00000000);

    // 5: back-pressure in RESP; stray requests ignored
    req_write = 1'b0; req_addr = 0; req_funct3 = F3_D; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("bp.enter", 64'(rsp_valid), 1);
    for (int i = 0; i < 5; i++) begin
      req_valid = i[0]; req_write = 1'b1; req_addr = 0;
      req_wdata = 64'hFFFFFFFFFFFFFFFF; req_funct3 = F3_D;
      @(posedge clk); #1;
      chk("bp.valid", 64'(rsp_valid), 1);
      chk("bp.rdata", rsp_rdata, 64'h1122334455667788);
      chk("bp.req_ready", 64'(req_ready), 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp.done", 64'(rsp_valid), 0);
    chk("bp.idle", 64'(req_ready), 1);
    chk("bp.e1", element1, 64'h1122334455667788);

    // 6a: reset during WAIT drops a pending store
    req_write = 1'b1; req_addr = 8; req_wdata = 64'hAAAAAAAAAAAAAAAA;
    req_funct3 = F3_D; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rw.wait", 64'(req_ready), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rw.rsp_valid", 64'(rsp_valid), 0);
    chk("rw.idle", 64'(req_ready), 1);
    chk("rw.e2", element2, 0);
    chk("rw.e1", element1, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("rw.later_valid", 64'(rsp_valid), 0);
    chk("rw.later_e2", element2, 0);

    // 6b: zero-wait instance; hold the other one in reset so it stays quiet
    reset = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0;
    chk("z.rst_e1", element1_0, 0);
    txn("z.sd0", 1, 1, 0, 64'h1122334455667788, F3_D, 0, 0, 1);
    chk("z.e1", element1_0, 64'h1122334455667788);
    txn("z.lb7", 1, 0, 7, 0, F3_B, 64'h11, 0, 1);
    txn("z.ld4", 1, 0, 4, 0, F3_D, 0, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
